// File: rtl/gip_rf_pkg.sv
// rtl/gip_rf_pkg.sv - shared constants and types for the GIP register file writeback controller
package gip_rf_pkg;

    localparam int RF_ADDR_W   = 5;
    localparam int RF_DATA_W   = 32;
    localparam int RF_NUM_REGS = 32;

    typedef struct packed {
        logic [RF_ADDR_W-1:0] addr;
        logic [RF_DATA_W-1:0] data;
    } t_wb_entry;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } t_rf_ctl_state;

endpackage

// File: rtl/gip_rf_wb_ctl_if.sv
// rtl/gip_rf_wb_ctl_if.sv - writeback, decode-read and register file port bundle
interface gip_rf_wb_ctl_if;
    import gip_rf_pkg::*;

    logic                 alu_wb_valid;
    logic [RF_ADDR_W-1:0] alu_wb_addr;
    logic [RF_DATA_W-1:0] alu_wb_data;
    logic                 alu_wb_ready;
    logic                 mem_wb_valid;
    logic [RF_ADDR_W-1:0] mem_wb_addr;
    logic [RF_DATA_W-1:0] mem_wb_data;
    logic                 mem_wb_ready;
    logic [RF_ADDR_W-1:0] rd_addr_0;
    logic [RF_ADDR_W-1:0] rd_addr_1;
    logic [RF_DATA_W-1:0] rd_data_0;
    logic [RF_DATA_W-1:0] rd_data_1;
    logic                 init_busy;
    logic [RF_ADDR_W-1:0] rf_rd_addr_0;
    logic [RF_ADDR_W-1:0] rf_rd_addr_1;
    logic [RF_DATA_W-1:0] rf_rd_data_0;
    logic [RF_DATA_W-1:0] rf_rd_data_1;
    logic                 rf_wr_enable;
    logic [RF_ADDR_W-1:0] rf_wr_addr;
    logic [RF_DATA_W-1:0] rf_wr_data;

    // master: pipeline stages plus the register file array; slave: the controller
    modport master (
        output alu_wb_valid, alu_wb_addr, alu_wb_data, input alu_wb_ready,
        output mem_wb_valid, mem_wb_addr, mem_wb_data, input mem_wb_ready,
        output rd_addr_0, rd_addr_1, input rd_data_0, rd_data_1, input init_busy,
        input rf_rd_addr_0, rf_rd_addr_1, output rf_rd_data_0, rf_rd_data_1,
        input rf_wr_enable, rf_wr_addr, rf_wr_data
    );

    modport slave (
        input alu_wb_valid, alu_wb_addr, alu_wb_data, output alu_wb_ready,
        input mem_wb_valid, mem_wb_addr, mem_wb_data, output mem_wb_ready,
        input rd_addr_0, rd_addr_1, output rd_data_0, rd_data_1, output init_busy,
        output rf_rd_addr_0, rf_rd_addr_1, input rf_rd_data_0, rf_rd_data_1,
        output rf_wr_enable, rf_wr_addr, rf_wr_data
    );

endinterface

// File: rtl/gip_rf_wb_fifo.sv
// rtl/gip_rf_wb_fifo.sv - 2-push/1-pop writeback FIFO exposing entries oldest-first
module gip_rf_wb_fifo
    import gip_rf_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PW   = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   push0,
    input  t_wb_entry              push0_entry,
    input  logic                   push1,
    input  t_wb_entry              push1_entry,
    input  logic                   pop,
    output logic [PW:0]            count,
    output t_wb_entry              head,
    output t_wb_entry [DEPTH-1:0]  age_entry,
    output logic [DEPTH-1:0]       age_valid
);

    t_wb_entry     slot_q [DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [PW:0]   count_q;

    // push1 is only ever raised together with push0, so it lands in the slot after push0
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push0) slot_q[wr_ptr_q] <= push0_entry;
            if (push1) slot_q[wr_ptr_q + PW'(1)] <= push1_entry;
            wr_ptr_q <= wr_ptr_q + PW'(push0) + PW'(push1);
            rd_ptr_q <= rd_ptr_q + PW'(pop);
            count_q  <= count_q + (PW+1)'(push0) + (PW+1)'(push1) - (PW+1)'(pop);
        end
    end

    // index 0 is the head; higher indices are younger
    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            age_entry[k] = slot_q[rd_ptr_q + PW'(k)];
            age_valid[k] = (PW+1)'(k) < count_q;
        end
    end

    assign count = count_q;
    assign head  = slot_q[rd_ptr_q];

endmodule

// File: rtl/gip_rf_wb_ctl.sv
// rtl/gip_rf_wb_ctl.sv - register file clear, writeback merge and bypassed read ports
module gip_rf_wb_ctl
    import gip_rf_pkg::*;
#(
    parameter int WB_FIFO_DEPTH = 4
) (
    input  logic          rf_clock,
    input  logic          rf_reset,
    gip_rf_wb_ctl_if.slave bus
);

    localparam int PW = $clog2(WB_FIFO_DEPTH);
    localparam int CW = PW + 1;

    t_rf_ctl_state             state_q, state_d;
    logic [RF_ADDR_W-1:0]      init_count_q;
    logic                      run;
    logic                      mem_ready, alu_ready, mem_acc, alu_acc;
    logic                      push0, push1, pop;
    t_wb_entry                 push0_entry, alu_entry, mem_entry, head;
    logic [CW-1:0]             count;
    t_wb_entry [WB_FIFO_DEPTH-1:0] age_entry;
    logic [WB_FIFO_DEPTH-1:0]  age_valid;
    logic                      wr_enable, init_busy;
    logic [RF_ADDR_W-1:0]      wr_addr;
    logic [RF_DATA_W-1:0]      wr_data, rd_data_0, rd_data_1;

    always_ff @(posedge rf_clock) begin
        if (!rf_reset) begin
            state_q      <= INIT;
            init_count_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == INIT) init_count_q <= init_count_q + 5'd1;
        end
    end

    // reset gates everything combinationally, so a mid-RUN reset silences outputs at once
    assign run       = rf_reset && (state_q == RUN);
    assign mem_ready = run && (count < CW'(WB_FIFO_DEPTH));
    assign alu_ready = run && ((count <= CW'(WB_FIFO_DEPTH - 2)) ||
                               ((count < CW'(WB_FIFO_DEPTH)) && !bus.mem_wb_valid));
    assign mem_acc   = bus.mem_wb_valid && mem_ready;
    assign alu_acc   = bus.alu_wb_valid && alu_ready;
    assign pop       = run && (count != '0);

    // memory result is the older instruction, so it enqueues ahead of the ALU result
    assign mem_entry   = '{addr: bus.mem_wb_addr, data: bus.mem_wb_data};
    assign alu_entry   = '{addr: bus.alu_wb_addr, data: bus.alu_wb_data};
    assign push0       = mem_acc || alu_acc;
    assign push1       = mem_acc && alu_acc;
    assign push0_entry = mem_acc ? mem_entry : alu_entry;

    gip_rf_wb_fifo #(.DEPTH(WB_FIFO_DEPTH)) u_fifo (
        .clk         (rf_clock),
        .resetn      (rf_reset),
        .push0       (push0),
        .push0_entry (push0_entry),
        .push1       (push1),
        .push1_entry (alu_entry),
        .pop         (pop),
        .count       (count),
        .head        (head),
        .age_entry   (age_entry),
        .age_valid   (age_valid)
    );

    always_comb begin
        state_d   = state_q;
        wr_enable = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        init_busy = 1'b1;
        if (rf_reset) begin
            case (state_q)
                INIT: begin
                    wr_enable = 1'b1;
                    wr_addr   = init_count_q;
                    if (init_count_q == RF_ADDR_W'(RF_NUM_REGS - 1)) state_d = RUN;
                end
                RUN: begin
                    init_busy = 1'b0;
                    if (pop) begin
                        wr_enable = 1'b1;
                        wr_addr   = head.addr;
                        wr_data   = head.data;
                    end
                end
                default: state_d = INIT;
            endcase
        end
    end

    // later (younger) matches override earlier ones; the head still bypasses while it is written
    always_comb begin
        rd_data_0 = '0;
        rd_data_1 = '0;
        if (run) begin
            rd_data_0 = bus.rf_rd_data_0;
            rd_data_1 = bus.rf_rd_data_1;
            for (int k = 0; k < WB_FIFO_DEPTH; k++) begin
                if (age_valid[k] && age_entry[k].addr == bus.rd_addr_0) rd_data_0 = age_entry[k].data;
                if (age_valid[k] && age_entry[k].addr == bus.rd_addr_1) rd_data_1 = age_entry[k].data;
            end
        end
    end

    assign bus.alu_wb_ready = alu_ready;
    assign bus.mem_wb_ready = mem_ready;
    assign bus.init_busy    = init_busy;
    assign bus.rd_data_0    = rd_data_0;
    assign bus.rd_data_1    = rd_data_1;
    assign bus.rf_rd_addr_0 = bus.rd_addr_0;
    assign bus.rf_rd_addr_1 = bus.rd_addr_1;
    assign bus.rf_wr_enable = wr_enable;
    assign bus.rf_wr_addr   = wr_addr;
    assign bus.rf_wr_data   = wr_data;

endmodule
